pll_lock_supervisor: RTL

Startup and health supervisor for the panel PLL. It runs on the 27 MHz board clock that also feeds the PLL's `clkin`. It drives the PLL's `reset` input, watches its `lock` output, and retries if lock times out. It releases `sys_rst_n` to the matrix-LED logic only after lock has been stable for a programmed time, and pulls it low again if lock is lost.

---
 rtl/pll_lock_supervisor_pkg.sv | 30 +++
 rtl/pll_lock_supervisor_sync_2ff.sv | 37 +++
 rtl/pll_lock_supervisor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor:
//   state_e     - supervisor FSM states
//   cnt_width() - width of the shared cycle counter
//   rty_width() - width of the retry counter (minimum 3 bits)
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int rty_width(input int max_retry);
    int w;
    w = $clog2(max_retry + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer bringing an asynchronous input into the clk domain.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, both stages clear to 0
//   d     - asynchronous input
//   q     - synchronized output (2 clk cycles latency)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Startup and health supervisor for the panel PLL. Pulses the PLL reset,
// waits for lock, retries on timeout, and releases the downstream reset only
// after lock has been stable for LOCK_STABLE cycles. Lock loss in RUN pulls
// the downstream reset and restarts acquisition.
// Ports:
//   clk        - 27 MHz board clock (also the PLL reference)
//   rst_n      - asynchronous active-low reset
//   pll_lock   - PLL lock indication, asynchronous to clk
//   pll_reset  - active-high reset to the PLL
//   sys_rst_n  - active-low reset to the downstream design
//   fail       - lock never achieved within the retry budget (terminal)
//   lock_lost  - sticky flag, lock dropped while in RUN
//   retry_cnt  - retries used in the current acquisition
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 270000,
  parameter int LOCK_STABLE    = 2700,
  parameter int MAX_RETRY      = 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pll_lock,
  output logic                              pll_reset,
  output logic                              sys_rst_n,
  output logic                              fail,
  output logic                              lock_lost,
  output logic [rty_width(MAX_RETRY)-1:0]   retry_cnt
);

  localparam int CW = cnt_width(LOCK_TIMEOUT, LOCK_STABLE, PLL_RST_CYCLES);
  localparam int RW = rty_width(MAX_RETRY);

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RTY_LIMIT = RW'(MAX_RETRY);

  logic lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            pll_reset_q, pll_reset_d;
  logic            sys_rst_n_q, sys_rst_n_d;
  logic            fail_q, fail_d;
  logic            lock_lost_q, lock_lost_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        // Lock wins over a simultaneous timeout.
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          cnt_d = '0;
          if (retry_q == RTY_LIMIT) begin
            state_d = FAIL;
          end else begin
            state_d = PLL_RST;
            retry_d = retry_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE: begin
        // A dropout restarts the timeout window without spending a retry.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d     = PLL_RST;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end
      end
      FAIL: begin
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Outputs decoded from the next state so they move with the state flop.
    pll_reset_d = (state_d == PLL_RST);
    sys_rst_n_d = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      fail_q      <= fail_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign fail      = fail_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;

endmodule
